multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//   Multi-cycle sequencer for the RV32I datapath; successor to the single-cycle opcode decoder.
//   Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath control lines.
//   Stalls on instruction and data memory handshakes.
//   Provides a PC write strobe, an IR load strobe and a retired-instruction counter.
// PARAMETERS
//   INST_R=7'b0110011  INST_I_LD=7'b0000011  INST_I_IMM=7'b0010011  INST_S=7'b0100011
//   INST_B=7'b1100011  INST_J=7'b1101111     INST_U=7'b0110111     (opcode encodings)
//   CNT_W=32           width of retired-instruction counter
// PORTS
//   clk        in   1      single clock; all state updates on posedge
//   rst        in   1      synchronous, active-high reset
//   opcode     in   7      IR[6:0]; stable from the cycle after irWrite
//   imemReady  in   1      instruction memory done; sampled while imemReq=1
//   dmemReady  in   1      data memory done; sampled while memRead|memWrite=1
//   branchTaken in  1      ALU compare result for B-type
//   imemReq    out  1      instruction fetch request
//   irWrite    out  1      load IR (1-cycle pulse)
//   pcWrite    out  1      update PC (1-cycle pulse, on retire)
//   pcSrc      out  1      0: PC+4, 1: branch/jump target
//   branch     out  1      B/J instruction in EXEC
//   memRead, memWrite, memToReg, ALUSrc, regWrite  out 1   datapath controls
//   ALUOp      out  2      00 add, 10 funct-decoded
//   retire     out  1      instruction completed (1-cycle pulse)
//   instret    out  CNT_W  retired-instruction count
//   illegalInst out 1      trap flag (see CONFIGURATION)
// BEHAVIOUR
//   - States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; reset state FETCH.
//   - Reset and gating:
//     - While rst=1, every output is 0, instret=0 and the state is forced to FETCH.
//     - First imemReq is in the cycle after rst falls.
//     - A reset mid-access drops imemReq/memRead/memWrite in that same cycle; no retire.
//   - FETCH: imemReq=1 until imemReady=1; on that same cycle irWrite=1 and next state is DECODE.
//   - DECODE: 1 cycle, no strobes; next state is EXEC.
//   - EXEC: set ALUOp/ALUSrc per class.
//     - R: ALUOp=10, ALUSrc=0 -> WB.
//     - I_IMM: ALUOp=00, ALUSrc=1 -> WB.
//     - I_LD, S: ALUOp=00, ALUSrc=1 -> MEM.
//     - U: ALUOp=00, ALUSrc=1 -> WB.
//     - J: branch=1, pcSrc=1 -> WB (link write).
//     - B: branch=1, ALUOp=10, pcSrc=branchTaken, pcWrite=1, retire=1 -> FETCH.
//     - Unknown opcode: pcWrite=1, retire=1 -> FETCH (NOP), unless the trap is enabled.
//   - MEM: memRead (LD) or memWrite (S) held high until dmemReady=1.
//     - LD -> WB.
//     - S: pcWrite=1 and retire=1 on the dmemReady cycle -> FETCH.
//   - WB: regWrite=1, memToReg=1 only for LD, pcSrc=1 only for J, pcWrite=1, retire=1 -> FETCH.
//   - Latency with zero-wait memory (ready in the request cycle): B=3, R/I/U/J/S=4, LD=5 cycles.
//   - Each wait cycle adds 1.
//   - ALUOp/ALUSrc/memToReg are held through MEM and WB for the same instruction.
//   - instret += 1 on each retire; wraps to 0 at 2^CNT_W.
//   - memRead and memWrite are never both 1.
//   - regWrite and memWrite are never both 1.
// CONFIGURATION
//   MC_ILLEGAL_TRAP_EN defined:
//     - Unknown opcode in EXEC -> TRAP, with no pcWrite and no retire.
//     - TRAP: illegalInst=1 and all other outputs 0.
//     - TRAP is left only by rst.
//   MC_ILLEGAL_TRAP_EN undefined: the TRAP state is absent, illegalInst is tied 0, and unknown opcodes are NOPs.
// STRUCTURE
//   rv_ctrl_pkg holds the opcode constants, state encodings, ALUOp codes and instruction-class enum.
//   opclass_decode is a combinational sub-module: opcode -> one-hot class {R,IMM,LD,S,B,J,U,ILL}.
//   The FSM, output logic and counter are in this module.
// TESTING
//   1. R-type, zero-wait memory: pulse sequence irWrite@1, regWrite+pcWrite+retire@4; instret 0->1.
//   2. LD with imemReady delayed 2 cycles and dmemReady delayed 3:
//      - memRead high for exactly 4 cycles; regWrite+memToReg in WB.
//      - retire at cycle 10.
//   3. B with branchTaken=1, then with branchTaken=0:
//      - retire in EXEC (cycle 3).
//      - pcSrc=1, then pcSrc=0; regWrite never 1.
//   4. rst asserted mid-MEM of S with dmemReady=0:
//      - memWrite=0 in the same cycle; no retire; instret=0.
//      - imemReq=1 the cycle after rst falls.
//   5. Opcode 7'h7F: with the macro, illegalInst=1 persists and there is no further imemReq.
//      Without the macro, retire=1 at cycle 3 and fetch resumes.
//   6. Preload instret=2^CNT_W-1 (CNT_W=4): one retire -> instret=0.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared constants and types for the RV32I multi-cycle control path.
// MC_ILLEGAL_TRAP_EN adds the TRAP state to the state encoding.
package rv_ctrl_pkg;

  // RV32I major opcodes (IR[6:0])
  localparam logic [6:0] INST_R     = 7'b0110011;
  localparam logic [6:0] INST_I_LD  = 7'b0000011;
  localparam logic [6:0] INST_I_IMM = 7'b0010011;
  localparam logic [6:0] INST_S     = 7'b0100011;
  localparam logic [6:0] INST_B     = 7'b1100011;
  localparam logic [6:0] INST_J     = 7'b1101111;
  localparam logic [6:0] INST_U     = 7'b0110111;

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Sequencer states; the encoding is visible on the debug port
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
`ifdef MC_ILLEGAL_TRAP_EN
    , ST_TRAP = 3'd5
`endif
  } state_t;

  // Instruction classes
  typedef enum logic [2:0] {
    CL_R, CL_IMM, CL_LD, CL_S, CL_B, CL_J, CL_U, CL_ILL
  } opclass_e;

  // One-hot class vector produced by the decoder
  typedef struct packed {
    logic r;
    logic imm;
    logic ld;
    logic s;
    logic b;
    logic j;
    logic u;
    logic ill;
  } opclass_t;

  // Map a major opcode onto its instruction class
  function automatic opclass_e classify(input logic [6:0] op);
    case (op)
      INST_R:     return CL_R;
      INST_I_IMM: return CL_IMM;
      INST_I_LD:  return CL_LD;
      INST_S:     return CL_S;
      INST_B:     return CL_B;
      INST_J:     return CL_J;
      INST_U:     return CL_U;
      default:    return CL_ILL;
    endcase
  endfunction

endpackage

// File: rtl/opclass_decode.sv
// Combinational opcode classifier: opcode -> one-hot {R,IMM,LD,S,B,J,U,ILL}.
module opclass_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_t   cls
);

  // Exactly one class bit is set for every opcode value
  always_comb begin
    cls = '0;
    case (classify(opcode))
      CL_R:    cls.r   = 1'b1;
      CL_IMM:  cls.imm = 1'b1;
      CL_LD:   cls.ld  = 1'b1;
      CL_S:    cls.s   = 1'b1;
      CL_B:    cls.b   = 1'b1;
      CL_J:    cls.j   = 1'b1;
      CL_U:    cls.u   = 1'b1;
      default: cls.ill = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with memory stalls,
// PC/IR strobes and a retired-instruction counter.
// Optional feature macro: MC_ILLEGAL_TRAP_EN (unknown opcodes park in TRAP
// instead of retiring as NOPs).
//
// Handshake: imemReq (and memRead/memWrite) is held high until the matching
// ready input is seen high in the same cycle; that cycle completes the access.
// Ready inputs are ignored while their request is low.
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             imemReady,
  input  logic             dmemReady,
  input  logic             branchTaken,
  output logic             imemReq,
  output logic             irWrite,
  output logic             pcWrite,
  output logic             pcSrc,
  output logic             branch,
  output logic             memRead,
  output logic             memWrite,
  output logic             memToReg,
  output logic             ALUSrc,
  output logic             regWrite,
  output logic [1:0]       ALUOp,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             illegalInst,
  output state_t           state_dbg
);

  state_t           state, state_nx;
  opclass_t         cls;
  logic [CNT_W-1:0] cnt_q;

  logic       c_imem_req, c_ir_write, c_pc_write, c_pc_src, c_branch;
  logic       c_mem_read, c_mem_write, c_mem_to_reg, c_alu_src, c_reg_write;
  logic [1:0] c_alu_op;
  logic       c_retire, c_illegal;

  // Operand selection that stays with an instruction from EXEC to retire
  logic       hold_src, hold_m2r;
  logic [1:0] hold_op;

  opclass_decode u_dec (
    .opcode (opcode),
    .cls    (cls)
  );

  assign hold_op  = (cls.r | cls.b) ? ALUOP_FUNCT : ALUOP_ADD;
  assign hold_src = cls.imm | cls.ld | cls.s | cls.u;
  assign hold_m2r = cls.ld;

  // State register; reset forces FETCH
  always_ff @(posedge clk) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_nx;
  end

  // Next-state and raw control decode
  always_comb begin
    state_nx     = state;
    c_imem_req   = 1'b0;
    c_ir_write   = 1'b0;
    c_pc_write   = 1'b0;
    c_pc_src     = 1'b0;
    c_branch     = 1'b0;
    c_mem_read   = 1'b0;
    c_mem_write  = 1'b0;
    c_mem_to_reg = 1'b0;
    c_alu_src    = 1'b0;
    c_reg_write  = 1'b0;
    c_alu_op     = ALUOP_ADD;
    c_retire     = 1'b0;
    c_illegal    = 1'b0;
    case (state)
      ST_FETCH: begin
        c_imem_req = 1'b1;
        if (imemReady) begin
          c_ir_write = 1'b1;
          state_nx   = ST_DECODE;
        end
      end
      ST_DECODE: state_nx = ST_EXEC;
      ST_EXEC: begin
        c_alu_op     = hold_op;
        c_alu_src    = hold_src;
        c_mem_to_reg = hold_m2r;
        if (cls.r | cls.imm | cls.u) begin
          state_nx = ST_WB;
        end else if (cls.ld | cls.s) begin
          state_nx = ST_MEM;
        end else if (cls.j) begin
          c_branch = 1'b1;
          c_pc_src = 1'b1;
          state_nx = ST_WB;
        end else if (cls.b) begin
          c_branch   = 1'b1;
          c_pc_src   = branchTaken;
          c_pc_write = 1'b1;
          c_retire   = 1'b1;
          state_nx   = ST_FETCH;
        end else begin
`ifdef MC_ILLEGAL_TRAP_EN
          state_nx   = ST_TRAP;
`else
          // Unknown opcode retires as a NOP
          c_pc_write = 1'b1;
          c_retire   = 1'b1;
          state_nx   = ST_FETCH;
`endif
        end
      end
      ST_MEM: begin
        c_alu_op     = hold_op;
        c_alu_src    = hold_src;
        c_mem_to_reg = hold_m2r;
        c_mem_read   = cls.ld;
        c_mem_write  = cls.s;
        if (!(cls.ld | cls.s)) begin
          state_nx = ST_FETCH;
        end else if (dmemReady) begin
          if (cls.ld) begin
            state_nx = ST_WB;
          end else begin
            c_pc_write = 1'b1;
            c_retire   = 1'b1;
            state_nx   = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        c_alu_op     = hold_op;
        c_alu_src    = hold_src;
        c_mem_to_reg = hold_m2r;
        c_reg_write  = 1'b1;
        c_pc_src     = cls.j;
        c_pc_write   = 1'b1;
        c_retire     = 1'b1;
        state_nx     = ST_FETCH;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      ST_TRAP: begin
        // Only reset leaves the trap
        c_illegal = 1'b1;
        state_nx  = ST_TRAP;
      end
`endif
      default: state_nx = ST_FETCH;
    endcase
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst)           cnt_q <= '0;
    else if (c_retire) cnt_q <= cnt_q + CNT_W'(1);
  end

  // Reset gates every output in the same cycle, including in-flight requests
  always_comb begin
    imemReq   = c_imem_req   & ~rst;
    irWrite   = c_ir_write   & ~rst;
    pcWrite   = c_pc_write   & ~rst;
    pcSrc     = c_pc_src     & ~rst;
    branch    = c_branch     & ~rst;
    memRead   = c_mem_read   & ~rst;
    memWrite  = c_mem_write  & ~rst;
    memToReg  = c_mem_to_reg & ~rst;
    ALUSrc    = c_alu_src    & ~rst;
    regWrite  = c_reg_write  & ~rst;
    ALUOp     = rst ? ALUOP_ADD : c_alu_op;
    retire    = c_retire     & ~rst;
    instret   = rst ? '0 : cnt_q;
    state_dbg = rst ? ST_FETCH : state;
`ifdef MC_ILLEGAL_TRAP_EN
    illegalInst = c_illegal & ~rst;
`else
    illegalInst = 1'b0 & c_illegal;
`endif
  end

endmodule
